// File: rtl/pixel_temporal_filter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_temporal_filter
// Brief    : Per-pixel temporal IIR smoother, avg += (in - avg) >>> k, with
//            first-frame seeding, bypass and same-address forwarding.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pixel_temporal_filter #(
  parameter  int MAX_ADDR = 63,
  parameter  int DATA_W   = 8,
  localparam int ADDRW    = $clog2(MAX_ADDR + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_bypass,
  input  logic [2:0]        i_shift,
  input  logic              i_wr_valid,
  input  logic [ADDRW-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_valid,
  output logic [ADDRW-1:0]  o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  logic                     w_in_range;
  logic                     w_accept;
  logic                     w_is_last;
  logic                     r_seed;

  logic                     r_s1_valid;
  logic [ADDRW-1:0]         r_s1_addr;
  logic [DATA_W-1:0]        r_s1_data;
  logic [2:0]               r_s1_shift;
  logic                     r_s1_bypass;
  logic                     r_s1_seed;

  logic                     r_fwd_valid;
  logic [ADDRW-1:0]         r_fwd_addr;
  logic [DATA_W-1:0]        r_fwd_data;

  logic [DATA_W-1:0]        r_mem [0:MAX_ADDR];
  logic [DATA_W-1:0]        r_rd_data;

  logic [DATA_W-1:0]        w_old;
  logic [2:0]               w_k;
  logic signed [DATA_W:0]   w_diff;
  logic signed [DATA_W:0]   w_step;
  logic [DATA_W-1:0]        w_new;

  // A power-of-two frame makes every address representable, so no range check.
  generate
    if (MAX_ADDR == (1 << ADDRW) - 1) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_partial_range
      assign w_in_range = (i_wr_addr <= ADDRW'(MAX_ADDR));
    end
  endgenerate

  assign w_accept  = i_wr_valid & w_in_range;
  assign w_is_last = (i_wr_addr == ADDRW'(MAX_ADDR));

  // A start pulse wins over the last-pixel clear so the coincident pixel seeds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seed <= 1'b1;
    end else if (i_start) begin
      r_seed <= 1'b1;
    end else if (w_accept && w_is_last) begin
      r_seed <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_data   <= '0;
      r_s1_shift  <= 3'd0;
      r_s1_bypass <= 1'b0;
      r_s1_seed   <= 1'b0;
    end else begin
      r_s1_valid  <= w_accept;
      r_s1_addr   <= i_wr_addr;
      r_s1_data   <= i_wr_data;
      r_s1_shift  <= i_shift;
      r_s1_bypass <= i_bypass;
      r_s1_seed   <= r_seed | i_start;
    end
  end

  // Average store: synchronous read, old data returned on a same-address write.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_rd_data <= r_mem[i_wr_addr];
    end
    if (r_s1_valid) begin
      r_mem[r_s1_addr] <= w_new;
    end
  end

  // The RAM read for a pixel right behind its own address misses the previous
  // write, so that value comes from the forward register instead.
  assign w_old  = (r_fwd_valid && (r_fwd_addr == r_s1_addr)) ? r_fwd_data : r_rd_data;
  assign w_k    = r_s1_bypass ? 3'd0 : r_s1_shift;
  assign w_diff = $signed({1'b0, r_s1_data}) - $signed({1'b0, w_old});
  assign w_step = w_diff >>> w_k;
  assign w_new  = (r_s1_seed || (w_k == 3'd0)) ? r_s1_data
                : DATA_W'($signed({1'b0, w_old}) + w_step);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_valid  <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else begin
      o_wr_valid  <= r_s1_valid;
      if (r_s1_valid) begin
        o_wr_addr <= r_s1_addr;
        o_wr_data <= r_s1_bypass ? r_s1_data : w_new;
      end
      r_fwd_valid <= r_s1_valid;
      r_fwd_addr  <= r_s1_addr;
      r_fwd_data  <= w_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_temporal_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_temporal_filter
// Brief    : Self-checking bench: vector table, behavioural frame model,
//            out-of-range instance and asynchronous reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_temporal_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, bypass = 1'b0, wv = 1'b0;
  logic [2:0] shift = 3'd0;
  logic [5:0] wa = 6'd0;
  logic [7:0] wd = 8'd0;
  logic       ov;
  logic [5:0] oa;
  logic [7:0] od;

  logic       v40 = 1'b0;
  logic [5:0] a40 = 6'd0;
  logic [7:0] d40 = 8'd0;
  logic       ov40;
  logic [5:0] oa40;
  logic [7:0] od40;

  always #5 clk = ~clk;

  pixel_temporal_filter #(.MAX_ADDR(63), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bypass(bypass), .i_shift(shift),
    .i_wr_valid(wv), .i_wr_addr(wa), .i_wr_data(wd),
    .o_wr_valid(ov), .o_wr_addr(oa), .o_wr_data(od)
  );

  pixel_temporal_filter #(.MAX_ADDR(40), .DATA_W(8)) dut40 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bypass(bypass), .i_shift(shift),
    .i_wr_valid(v40), .i_wr_addr(a40), .i_wr_data(d40),
    .o_wr_valid(ov40), .o_wr_addr(oa40), .o_wr_data(od40)
  );

  typedef struct {int due; int addr; int data; int tab;} exp_t;
  typedef struct {bit v; int a; int d; int k; bit byp; bit st; int exp;} vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   avg [64];
  bit   m_seed = 1'b1;
  exp_t q [$];
  exp_t q40 [$];
  vec_t vecs [$];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int floordiv(input int n, input int m);
    if (n >= 0) return n / m;
    return -((-n + m - 1) / m);
  endfunction

  task automatic check_main();
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("out_valid", int'(ov), 1);
      check("out_addr", int'(oa), e.addr);
      check("out_data", int'(od), e.data);
      if (e.tab >= 0) check("table_data", int'(od), e.tab);
    end else begin
      check("idle_valid", int'(ov), 0);
    end
  endtask

  task automatic check_40();
    exp_t e;
    if (q40.size() > 0 && q40[0].due == cyc) begin
      e = q40.pop_front();
      check("r40_valid", int'(ov40), 1);
      check("r40_addr", int'(oa40), e.addr);
      check("r40_data", int'(od40), e.data);
    end else begin
      check("r40_idle", int'(ov40), 0);
    end
  endtask

  // One clock of the main instance: drive, model the pixel, advance, check.
  task automatic step(input bit v, input int a, input int d, input int k,
                      input bit byp, input bit st, input int tab);
    int kk, nw, out;
    wv = v; wa = a[5:0]; wd = d[7:0]; shift = k[2:0]; bypass = byp; start = st;
    if (v) begin
      kk = byp ? 0 : k;
      if (m_seed || st || kk == 0) nw = d;
      else nw = avg[a] + floordiv(d - avg[a], 1 << kk);
      avg[a] = nw;
      out = byp ? d : nw;
      q.push_back('{cyc + 2, a, out, tab});
    end
    if (st) m_seed = 1'b1;
    else if (v && a == 63) m_seed = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check_main();
    check_40();
  endtask

  task automatic step40(input bit v, input int a, input int d, input int k, input int exp);
    v40 = v; a40 = a[5:0]; d40 = d[7:0];
    if (exp >= 0) q40.push_back('{cyc + 2, a, exp, -1});
    step(1'b0, 0, 0, k, 1'b0, 1'b0, -1);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_valid", int'(ov), 0);
    check("rst_addr", int'(oa), 0);
    check("rst_data", int'(od), 0);
    check("rst_valid40", int'(ov40), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Seed then blend, hazard chain, bypass, re-seed, start-with-input.
    vecs.push_back('{1, 5, 100, 1, 0, 0, 100});
    vecs.push_back('{1, 63,  7, 1, 0, 0,   7});
    vecs.push_back('{0, 0,   0, 0, 0, 0,  -1});
    vecs.push_back('{1, 5, 200, 1, 0, 0, 150});
    vecs.push_back('{0, 0,   0, 0, 0, 0,  -1});
    vecs.push_back('{1, 5,   0, 1, 0, 0,  75});
    vecs.push_back('{0, 0,   0, 0, 0, 0,  -1});
    vecs.push_back('{1, 5,   0, 1, 0, 0,  37});
    vecs.push_back('{1, 3,   0, 0, 0, 0,   0});
    vecs.push_back('{0, 0,   0, 0, 0, 0,  -1});
    vecs.push_back('{1, 3,  64, 2, 0, 0,  16});
    vecs.push_back('{1, 3,  64, 2, 0, 0,  28});
    vecs.push_back('{1, 3,  64, 2, 0, 0,  37});
    vecs.push_back('{1, 3,  64, 2, 0, 0,  43});
    vecs.push_back('{1, 10, 80, 0, 0, 0,  80});
    vecs.push_back('{1, 10,160, 3, 1, 0, 160});
    vecs.push_back('{1, 10,160, 3, 0, 0, 160});
    vecs.push_back('{1, 20, 10, 0, 0, 0,  10});
    vecs.push_back('{0, 0,   0, 0, 0, 1,  -1});
    vecs.push_back('{1, 20,250, 4, 0, 0, 250});
    vecs.push_back('{1, 63,  0, 0, 0, 0,   0});
    vecs.push_back('{1, 20,  0, 4, 0, 0, 234});
    vecs.push_back('{1, 30, 99, 2, 0, 1,  99});
    vecs.push_back('{1, 30,  0, 2, 0, 0,   0});
    vecs.push_back('{1, 63,  5, 0, 0, 0,   5});
    vecs.push_back('{1, 30,  8, 1, 0, 0,   4});
    foreach (vecs[i])
      step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].k, vecs[i].byp, vecs[i].st, vecs[i].exp);
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b0, -1);

    // Full frame at k=0 with gaps: pass-through, exact 2-cycle latency.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) step(1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
      step(1'b1, i, int'($urandom_range(0, 255)), 0, 1'b0, 1'b0, -1);
    end
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b0, -1);

    // Randomised traffic against the frame model.
    begin
      int la = 0;
      for (int n = 0; n < 800; n++) begin
        int a;
        a = ($urandom_range(0, 3) == 0) ? la : int'($urandom_range(0, 63));
        la = a;
        step($urandom_range(0, 9) < 7, a, int'($urandom_range(0, 255)),
             int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
             $urandom_range(0, 49) == 0, -1);
      end
    end
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b0, -1);

    // Out-of-range drop on the 41-pixel instance (still seeded from reset).
    step40(1'b1, 50,   9, 1, -1);
    step40(1'b1, 41,   3, 1, -1);
    step40(1'b1, 40, 100, 1, 100);
    step40(1'b1, 50,   9, 1, -1);
    step40(1'b0, 0,    0, 1, -1);
    step40(1'b1, 40,   0, 1, 50);
    step40(1'b0, 0,    0, 1, -1);
    step40(1'b0, 0,    0, 1, -1);
    step40(1'b0, 0,    0, 1, -1);

    // Asynchronous reset with pixels in flight.
    step(1'b1, 7, 200, 1, 1'b0, 1'b0, -1);
    step(1'b1, 8,  50, 1, 1'b0, 1'b0, -1);
    wv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(ov), 0);
    q.delete();
    m_seed = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    step(1'b1, 7, 33, 3, 1'b0, 1'b0, 33);
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
